// File: rtl/am2909_stack_file.sv
// Return-address stack file for a 4-bit microprogram sequencer slice.
// Optional sticky overflow/underflow flag on o_err when AM2909_STACK_ERR_EN is defined.
module am2909_stack_file #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_cp,
    input  logic             i_clr_n,
    input  logic             i_fe,
    input  logic             i_pup,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_f,
    output logic             o_full,
    output logic             o_empty
`ifdef AM2909_STACK_ERR_EN
    ,
    output logic             o_err
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_file [DEPTH];
    logic [PW-1:0]    r_sp;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_top;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_sp_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_top_nxt;

    assign w_push = ~i_fe & i_pup;
    assign w_pop  = ~i_fe & ~i_pup;

    // r_top mirrors file[SP] so F is a flop output; a push bypasses the write into it.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        w_top_nxt = r_top;
        if (w_push) begin
            w_sp_nxt  = r_sp + PW'(1);
            w_top_nxt = i_din;
            if (r_cnt != CW'(DEPTH)) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else if (w_pop) begin
            w_sp_nxt  = r_sp - PW'(1);
            w_top_nxt = r_file[w_sp_nxt];
            if (r_cnt != CW'(0)) begin
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge i_cp) begin
        if (!i_clr_n) begin
            r_sp    <= PW'(DEPTH - 1);
            r_cnt   <= CW'(0);
            r_top   <= r_file[PW'(DEPTH - 1)];
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_top   <= w_top_nxt;
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_empty <= (w_cnt_nxt == CW'(0));
        end
    end

    // Storage is not cleared by reset; a push during reset is discarded.
    always_ff @(posedge i_cp) begin
        if (i_clr_n && w_push) begin
            r_file[w_sp_nxt] <= i_din;
        end
    end

    assign o_f     = r_top;
    assign o_full  = r_full;
    assign o_empty = r_empty;

`ifdef AM2909_STACK_ERR_EN
    logic r_err;
    logic w_ovf;
    logic w_udf;

    assign w_ovf = w_push & r_full;
    assign w_udf = w_pop & r_empty;

    always_ff @(posedge i_cp) begin
        if (!i_clr_n) begin
            r_err <= 1'b0;
        end else if (w_ovf || w_udf) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule
